// File: rtl/mem_wb_pipe_reg.sv
// rtl/mem_wb_pipe_reg.sv - MEM/WB pipeline register; optional stall/flush via MEM_WB_STALL_FLUSH_EN
module mem_wb_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     alu_result_in,
    input  logic [DATA_W-1:0]     mem_data_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic                  reg_write_in,
    input  logic                  mem_to_reg_in,
`ifdef MEM_WB_STALL_FLUSH_EN
    input  logic                  stall,
    input  logic                  flush,
`endif
    output logic [DATA_W-1:0]     alu_result_out,
    output logic [DATA_W-1:0]     mem_data_out,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic                  reg_write_out,
    output logic                  mem_to_reg_out
);

    logic [DATA_W-1:0]     r_alu_result;
    logic [DATA_W-1:0]     r_mem_data;
    logic [REG_ADDR_W-1:0] r_rd;
    logic                  r_reg_write;
    logic                  r_mem_to_reg;

    // A cleared stage is a bubble: reg_write=0 guarantees no register-file write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_result <= '0;
            r_mem_data   <= '0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end
`ifdef MEM_WB_STALL_FLUSH_EN
        else if (flush) begin
            r_alu_result <= '0;
            r_mem_data   <= '0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end
        else if (!stall) begin
            r_alu_result <= alu_result_in;
            r_mem_data   <= mem_data_in;
            r_rd         <= rd_in;
            r_reg_write  <= reg_write_in;
            r_mem_to_reg <= mem_to_reg_in;
        end
`else
        else begin
            r_alu_result <= alu_result_in;
            r_mem_data   <= mem_data_in;
            r_rd         <= rd_in;
            r_reg_write  <= reg_write_in;
            r_mem_to_reg <= mem_to_reg_in;
        end
`endif
    end

    assign alu_result_out = r_alu_result;
    assign mem_data_out   = r_mem_data;
    assign rd_out         = r_rd;
    assign reg_write_out  = r_reg_write;
    assign mem_to_reg_out = r_mem_to_reg;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// tb/tb_mem_wb_pipe_reg.sv - self-checking bench for mem_wb_pipe_reg
module tb_mem_wb_pipe_reg;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct packed {
        logic [DW-1:0] alu;
        logic [DW-1:0] mem;
        logic [AW-1:0] rd;
        logic          rw;
        logic          m2r;
    } wb_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] alu_result_in, mem_data_in;
    logic [AW-1:0] rd_in;
    logic          reg_write_in, mem_to_reg_in;
    logic [DW-1:0] alu_result_out, mem_data_out;
    logic [AW-1:0] rd_out;
    logic          reg_write_out, mem_to_reg_out;
`ifdef MEM_WB_STALL_FLUSH_EN
    logic          stall, flush;
`endif

    int  checks = 0;
    int  errors = 0;
    wb_t model_q;

    always #5 clk = ~clk;

    mem_wb_pipe_reg #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_result_in  (alu_result_in),
        .mem_data_in    (mem_data_in),
        .rd_in          (rd_in),
        .reg_write_in   (reg_write_in),
        .mem_to_reg_in  (mem_to_reg_in),
`ifdef MEM_WB_STALL_FLUSH_EN
        .stall          (stall),
        .flush          (flush),
`endif
        .alu_result_out (alu_result_out),
        .mem_data_out   (mem_data_out),
        .rd_out         (rd_out),
        .reg_write_out  (reg_write_out),
        .mem_to_reg_out (mem_to_reg_out)
    );

    task automatic check(input string tag, input wb_t got, input wb_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got alu=%h mem=%h rd=%0d rw=%b m2r=%b, expected alu=%h mem=%h rd=%0d rw=%b m2r=%b",
                     tag, got.alu, got.mem, got.rd, got.rw, got.m2r,
                     exp.alu, exp.mem, exp.rd, exp.rw, exp.m2r);
        end
    endtask

    function automatic wb_t outs();
        return '{alu: alu_result_out, mem: mem_data_out, rd: rd_out,
                 rw: reg_write_out, m2r: mem_to_reg_out};
    endfunction

    task automatic drive(input logic [DW-1:0] a, input logic [DW-1:0] m,
                         input logic [AW-1:0] r, input logic w, input logic t);
        alu_result_in = a;
        mem_data_in   = m;
        rd_in         = r;
        reg_write_in  = w;
        mem_to_reg_in = t;
    endtask

    // Model: next = 0 on reset/flush, previous on stall, else the sampled inputs.
    task automatic tick(input string tag);
        wb_t nxt;
        nxt = '{alu: alu_result_in, mem: mem_data_in, rd: rd_in,
                rw: reg_write_in, m2r: mem_to_reg_in};
`ifdef MEM_WB_STALL_FLUSH_EN
        if (flush)      nxt = '0;
        else if (stall) nxt = model_q;
`endif
        if (rst) nxt = '0;
        @(posedge clk);
        #1;
        model_q = nxt;
        check(tag, outs(), model_q);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
`ifdef MEM_WB_STALL_FLUSH_EN
        stall = 1'b0;
        flush = 1'b0;
`endif
        drive('0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        tick("reset_1");
        tick("reset_2");

        rst = 1'b0;
        drive(32'hAAAABBBB, 32'h11112222, 5'd3, 1'b1, 1'b0);
        tick("load_set2");

        drive(32'hCCCCDDDD, 32'h33334444, 5'd7, 1'b1, 1'b1);
        #1 check("no_comb_path", outs(), model_q);
        tick("b2b_set3");

        rst = 1'b1;
        tick("reset_midstream");
        rst = 1'b0;
        tick("reload_set3");

        #2 rst = 1'b1;
        #1 check("sync_rst_pulse", outs(), model_q);
        #1 rst = 1'b0;
        tick("after_pulse");

        drive(32'h0, 32'hFFFFFFFF, 5'd0, 1'b1, 1'b0);
        tick("x0_passthrough");
        drive('1, '1, '1, 1'b1, 1'b1);
        tick("all_ones");

`ifdef MEM_WB_STALL_FLUSH_EN
        stall = 1'b1;
        drive(32'h12345678, 32'h9ABCDEF0, 5'd9, 1'b0, 1'b1);
        tick("stall_hold");
        stall = 1'b0;
        flush = 1'b1;
        tick("flush_clear");
        flush = 1'b0;
        tick("load_after_flush");
        stall = 1'b1;
        rst   = 1'b1;
        tick("rst_over_stall");
        stall = 1'b0;
        rst   = 1'b0;
`endif

        for (int i = 0; i < 300; i++) begin
            drive($urandom, $urandom, AW'($urandom), 1'($urandom), 1'($urandom));
            rst = ($urandom_range(0, 7) == 0);
`ifdef MEM_WB_STALL_FLUSH_EN
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
`endif
            #1 check("rand_no_comb", outs(), model_q);
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
